// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive monitor and its FIFO.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead FIFO: the head entry is presented on rdata whenever the FIFO is non-empty.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [AW:0]      wr_ptr_d;
  logic [AW:0]      rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver: synchronizer, bit-timing FSM and a show-ahead byte FIFO with
// sticky framing/overflow status and a running count of accepted bytes.
module uart_rx_monitor
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [7:0]  data,
  output logic        valid,
  input  logic        ready,
  output logic        frame_err,
  output logic        overflow,
  output logic [31:0] byte_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  logic                 sync1_q;
  logic                 sync2_q;
  logic                 rx_prev_q;
  logic                 rx_s;
  rx_state_e            state_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic                 frame_err_q;
  logic                 overflow_q;
  logic [31:0]          byte_count_q;
  logic [31:0]          byte_count_d;

  logic                 fall;
  logic                 cnt_zero;
  logic                 stop_sample;
  logic                 push_req;
  logic                 pop_req;
  logic                 push_ok;
  logic [7:0]           fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FW:0]          fifo_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  assign rx_s         = sync2_q;
  assign fall         = rx_prev_q && !rx_s;
  assign cnt_zero     = (cnt_q == '0);
  assign stop_sample  = (state_q == STOP) && cnt_zero;
  assign push_req     = stop_sample && rx_s;
  assign pop_req      = valid && ready;
  // A full FIFO still takes the byte when the consumer frees a slot on the same edge.
  assign push_ok      = push_req && (!fifo_full || pop_req);
  assign shift_d      = {rx_s, shift_q[DATA_BITS-1:1]};
  assign byte_count_d = byte_count_q + 32'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
      byte_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          bit_cnt_q <= '0;
          cnt_q     <= HALF_LOAD;
          if (fall) begin
            state_q <= START;
          end
        end
        START: begin
          if (cnt_zero) begin
            if (!rx_s) begin
              state_q <= DATA;
              cnt_q   <= FULL_LOAD;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DATA: begin
          if (cnt_zero) begin
            shift_q   <= shift_d;
            cnt_q     <= FULL_LOAD;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        STOP: begin
          if (cnt_zero) begin
            if (rx_s) begin
              state_q <= IDLE;
              if (push_ok) begin
                byte_count_q <= byte_count_d;
              end else begin
                overflow_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= BREAK;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        // Hold off until the line returns high so a long break cannot look like a start bit.
        BREAK: begin
          if (rx_s) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .wdata (shift_q),
    .pop   (pop_req),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign valid      = (fifo_count != '0);
  assign data       = fifo_empty ? 8'h00 : fifo_rdata;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;
  assign byte_count = byte_count_q;

endmodule
